// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared types and constants for the sysid checker
package sysid_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID        = 32'hACD5_1302;
    localparam logic [31:0] SYSID_EXP_TIMESTAMP = 32'h5310_4B65;

endpackage

// File: rtl/sysid_check_stall_timer.sv
// sysid_check_stall_timer: clearable stall counter flagging when LIMIT stall cycles have elapsed
module sysid_check_stall_timer
    import sysid_check_pkg::*;
#(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // count stall cycles; clear has priority so each read starts from zero
    always_ff @(posedge clock) begin
        if (!reset_n || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign terminal = (cnt == W'(LIMIT));

endmodule

// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker: reads sysid ID and timestamp words over Avalon-MM and reports a match;
// define SYSID_CHECK_TIMEOUT_EN to add a per-read waitrequest stall timeout and the timeout port
module soc_system_sysid_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = SYSID_EXP_ID,
    parameter logic [31:0] EXP_TIMESTAMP  = SYSID_EXP_TIMESTAMP,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
`ifdef SYSID_CHECK_TIMEOUT_EN
    output logic        pass,
    output logic        timeout
`else
    output logic        pass
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    sysid_chk_state_t state, state_nxt;
    logic             tmo_hit;
    logic             ts_match;
    logic             accept;

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign ts_match    = (avm_readdata == EXP_TIMESTAMP);
    assign accept      = (state == IDLE) && start;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic stall_tc;

    sysid_check_stall_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!(avm_read && avm_waitrequest)),
        .enable  (avm_read && avm_waitrequest),
        .terminal(stall_tc)
    );

    assign tmo_hit = avm_read && avm_waitrequest && stall_tc;

    // timeout flag: cleared by an accepted start, set when a read gives up
    always_ff @(posedge clock) begin
        if (!reset_n || accept)
            timeout <= 1'b0;
        else if (tmo_hit)
            timeout <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: a read advances when waitrequest is low, or bails to DONE on timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RD_ID : IDLE;
            RD_ID:   state_nxt = tmo_hit ? DONE : (!avm_waitrequest ? RD_TS : RD_ID);
            RD_TS:   state_nxt = (tmo_hit || !avm_waitrequest) ? DONE : RD_TS;
            default: state_nxt = IDLE;
        endcase
    end

    // registered status and captured results; results hold until the next accepted start
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            pass     <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            if (accept) begin
                id_value <= '0;
                ts_value <= '0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                pass     <= 1'b0;
            end
            if (state == RD_ID && !avm_waitrequest) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXP_ID);
            end
            if (state == RD_TS && !avm_waitrequest) begin
                ts_value <= avm_readdata;
                ts_ok    <= ts_match;
                pass     <= id_ok && (ts_match || !CHECK_TS);
            end
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// tb_soc_system_sysid_checker: directed table-driven bench for soc_system_sysid_checker
module tb_soc_system_sysid_checker;

    logic        clock, reset_n, start, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, pass;
    logic [31:0] id_value, ts_value;
    logic        nc_avm_address, nc_avm_read, nc_busy, nc_done, nc_id_ok, nc_ts_ok, nc_pass;
    logic [31:0] nc_id_value, nc_ts_value;
`ifdef SYSID_CHECK_TIMEOUT_EN
    logic        timeout, nc_timeout;
`endif

    logic [31:0] cur_id, cur_ts;
    logic        force_wr;
    int          stall_n;
    int          wcnt;
    int          checks, errors;
    int          lat, bsy;
    logic        addr_log [64];
    logic        rd_log [64];

    typedef struct {
        logic [31:0] id_w;
        logic [31:0] ts_w;
        logic        e_id_ok;
        logic        e_ts_ok;
        logic        e_pass;
        logic        e_pass_nc;
    } vec_t;

    vec_t vecs [4];

    assign avm_waitrequest = force_wr || (avm_read && (wcnt < stall_n));
    assign avm_readdata    = avm_address ? cur_ts : cur_id;

    always @(posedge clock) wcnt <= (avm_read && avm_waitrequest) ? wcnt + 1 : 0;

    soc_system_sysid_checker #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .id_value       (id_value),
        .ts_value       (ts_value),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
`ifdef SYSID_CHECK_TIMEOUT_EN
        .pass           (pass),
        .timeout        (timeout)
`else
        .pass           (pass)
`endif
    );

    soc_system_sysid_checker #(
        .CHECK_TS      (1'b0),
        .TIMEOUT_CYCLES(8)
    ) dut_nc (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (nc_avm_address),
        .avm_read       (nc_avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (nc_busy),
        .done           (nc_done),
        .id_value       (nc_id_value),
        .ts_value       (nc_ts_value),
        .id_ok          (nc_id_ok),
        .ts_ok          (nc_ts_ok),
`ifdef SYSID_CHECK_TIMEOUT_EN
        .pass           (nc_pass),
        .timeout        (nc_timeout)
`else
        .pass           (nc_pass)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_check();
        lat = -1;
        bsy = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 64; c++) begin
            addr_log[c] = avm_address;
            rd_log[c]   = avm_read;
            if (busy) bsy++;
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int bad, n;
        logic [15:0] mask;
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        force_wr = 1'b0;
        stall_n  = 0;
        cur_id   = 32'h0;
        cur_ts   = 32'h0;
        vecs[0] = '{32'hACD5_1302, 32'h5310_4B65, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'hACD5_1302, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0000, 32'h5310_4B65, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hACD5_1303, 32'h5310_4B64, 1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_pass", pass, 0);
        chk("rst_id_value", id_value, 0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            cur_id = vecs[i].id_w;
            cur_ts = vecs[i].ts_w;
            run_check();
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_busy_cycles", i), bsy, 3);
            chk($sformatf("v%0d_addr_c1", i), addr_log[1], 0);
            chk($sformatf("v%0d_addr_c2", i), addr_log[2], 1);
            chk($sformatf("v%0d_read_c1c2", i), rd_log[1] & rd_log[2], 1);
            chk($sformatf("v%0d_read_c3", i), rd_log[3], 0);
            chk($sformatf("v%0d_id_value", i), id_value, vecs[i].id_w);
            chk($sformatf("v%0d_ts_value", i), ts_value, vecs[i].ts_w);
            chk($sformatf("v%0d_id_ok", i), id_ok, vecs[i].e_id_ok);
            chk($sformatf("v%0d_ts_ok", i), ts_ok, vecs[i].e_ts_ok);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].e_pass);
            chk($sformatf("v%0d_pass_nocheck", i), nc_pass, vecs[i].e_pass_nc);
            tick();
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_pass_hold", i), pass, vecs[i].e_pass);
        end
        cur_id  = 32'hACD5_1302;
        cur_ts  = 32'h5310_4B65;
        stall_n = 5;
        run_check();
        chk("stall_latency", lat, 13);
        bad = 0;
        for (int c = 1; c <= 12; c++)
            if (addr_log[c] !== (c >= 7) || rd_log[c] !== 1'b1) bad++;
        chk("stall_bus_stable", bad, 0);
        chk("stall_id_value", id_value, 32'hACD5_1302);
        chk("stall_ts_value", ts_value, 32'h5310_4B65);
        chk("stall_pass", pass, 1);
        stall_n = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) n++;
            tick();
        end
        chk("start_in_rdts_done_count", n, 1);
        chk("start_in_rdts_idle", busy, 0);
        start = 1'b1;
        tick();
        mask = '0;
        for (int c = 1; c <= 12; c++) begin
            mask[c] = done;
            tick();
        end
        start = 1'b0;
        chk("held_start_done_mask", mask, 16'h0888);
        for (int c = 0; c < 6; c++) tick();
        chk("pre_reset_id_value", id_value, 32'hACD5_1302);
        stall_n = 20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midread_read_high", avm_read, 1);
        reset_n = 1'b0;
        tick();
        chk("midread_rst_read", avm_read, 0);
        chk("midread_rst_busy", busy, 0);
        chk("midread_rst_id_value", id_value, 0);
        chk("midread_rst_pass", pass, 0);
        reset_n = 1'b1;
        stall_n = 0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) n++;
            tick();
        end
        chk("midread_no_done", n, 0);
`ifdef SYSID_CHECK_TIMEOUT_EN
        force_wr = 1'b1;
        run_check();
        force_wr = 1'b0;
        chk("tmo_latency", lat, 10);
        chk("tmo_timeout", timeout, 1);
        chk("tmo_pass", pass, 0);
        chk("tmo_ts_value", ts_value, 0);
        chk("tmo_id_value", id_value, 0);
        bad = 0;
        for (int c = 1; c <= 9; c++)
            if (addr_log[c] !== 1'b0 || rd_log[c] !== 1'b1) bad++;
        chk("tmo_no_ts_read", bad, 0);
        chk("tmo_read_dropped", rd_log[10], 0);
        tick();
        stall_n = 8;
        run_check();
        stall_n = 0;
        chk("edge_latency", lat, 19);
        chk("edge_timeout", timeout, 0);
        chk("edge_pass", pass, 1);
        chk("edge_ts_value", ts_value, 32'h5310_4B65);
        tick();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
